// File: rtl/composite_pixel_fetch.sv
// composite_pixel_fetch: scaled line-buffer fetch -> palette lookup -> RGB444; 3 cycles strobe-to-RGB, no backpressure.
// Define COMPOSITE_FETCH_HSCALE_EN for fractional hscale stepping; otherwise the address tracks the pixel index.
module composite_pixel_fetch #(
  parameter int LB_AW         = 10,
  parameter int ACTIVE_PIXELS = 640
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             next_frame,
  input  logic             next_line,
  input  logic             next_pixel,
  input  logic [7:0]       hscale,
  input  logic [9:0]       hstart,
  input  logic [9:0]       hstop,
  input  logic [7:0]       border_color,
  output logic             lb_bank,
  output logic [LB_AW-1:0] lb_rd_addr,
  input  logic [7:0]       lb_rd_data,
  output logic [7:0]       pal_addr,
  input  logic [11:0]      pal_data,
  output logic [11:0]      palette_rgb_data
);

  localparam logic [9:0] PIX_MAX = ACTIVE_PIXELS[9:0];

  logic             phase;
  logic             strobe;
  logic             line_ok;
  logic [9:0]       pix_idx;
  logic [9:0]       hstart_q;
  logic [9:0]       hstop_q;
  logic [7:0]       border_q;
  logic             win1;
  logic             act1;
  logic             act2;
  logic             in_window;
  logic [LB_AW-1:0] addr_cur;

  // Nothing is fetched after reset until a line start has latched a fresh config.
  assign strobe    = next_pixel & phase & ~next_line & line_ok;
  assign in_window = (pix_idx >= hstart_q) && (pix_idx < hstop_q);

`ifdef COMPOSITE_FETCH_HSCALE_EN
  localparam int ACC_W = LB_AW + 7;
  logic [ACC_W-1:0] acc;
  logic [7:0]       hscale_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      hscale_q <= 8'd128;
    end else if (next_line) begin
      acc      <= '0;
      hscale_q <= hscale;
    end else if (strobe) begin
      acc      <= acc + {{(ACC_W-8){1'b0}}, hscale_q};
    end
  end

  assign addr_cur = acc[ACC_W-1:7];
`else
  logic [LB_AW-1:0] acc;
  logic             unused_hscale;

  assign unused_hscale = ^hscale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (next_line) begin
      acc <= '0;
    end else if (strobe) begin
      acc <= acc + LB_AW'(1);
    end
  end

  assign addr_cur = acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      line_ok    <= 1'b0;
      pix_idx    <= '0;
      hstart_q   <= '0;
      hstop_q    <= PIX_MAX;
      border_q   <= '0;
      lb_rd_addr <= '0;
      win1       <= 1'b0;
    end else if (next_line) begin
      // A coincident active clock is the first (phase 0) clock of the line.
      phase      <= next_pixel;
      line_ok    <= 1'b1;
      pix_idx    <= '0;
      hstart_q   <= hstart;
      hstop_q    <= hstop;
      border_q   <= border_color;
      lb_rd_addr <= '0;
      win1       <= 1'b0;
    end else begin
      if (next_pixel) phase <= ~phase;
      if (strobe) begin
        lb_rd_addr <= addr_cur;
        win1       <= in_window;
        if (pix_idx < PIX_MAX) pix_idx <= pix_idx + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act1             <= 1'b0;
      act2             <= 1'b0;
      pal_addr         <= '0;
      palette_rgb_data <= 12'h000;
      lb_bank          <= 1'b0;
    end else begin
      act1             <= next_pixel & (line_ok | next_line);
      act2             <= act1;
      pal_addr         <= (act1 & win1) ? lb_rd_data : border_q;
      palette_rgb_data <= act2 ? pal_data : 12'h000;
      if (next_frame)     lb_bank <= 1'b0;
      else if (next_line) lb_bank <= ~lb_bank;
    end
  end

endmodule

// File: tb/tb_composite_pixel_fetch.sv
module tb_composite_pixel_fetch;
  localparam int LB_AW = 10;
  localparam int AP    = 640;
  localparam int ACCW  = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             next_frame, next_line, next_pixel;
  logic [7:0]       hscale;
  logic [9:0]       hstart, hstop;
  logic [7:0]       border_color;
  logic             lb_bank;
  logic [LB_AW-1:0] lb_rd_addr;
  logic [7:0]       lb_rd_data;
  logic [7:0]       pal_addr;
  logic [11:0]      pal_data;
  logic [11:0]      palette_rgb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int lbfn(input int a);
    return a & 255;
  endfunction

  function automatic int palfn(input int p);
    return ((p & 15) << 8) | ((p ^ 8'h3C) & 255);
  endfunction

  // External RAM models: data for the presented address is ready by the next edge.
  assign lb_rd_data = 8'(lbfn(int'(lb_rd_addr)));
  assign pal_data   = 12'(palfn(int'(pal_addr)));

  composite_pixel_fetch #(.LB_AW(LB_AW), .ACTIVE_PIXELS(AP)) dut (
    .clk(clk), .rst_n(rst_n), .next_frame(next_frame), .next_line(next_line),
    .next_pixel(next_pixel), .hscale(hscale), .hstart(hstart), .hstop(hstop),
    .border_color(border_color), .lb_bank(lb_bank), .lb_rd_addr(lb_rd_addr),
    .lb_rd_data(lb_rd_data), .pal_addr(pal_addr), .pal_data(pal_data),
    .palette_rgb_data(palette_rgb_data)
  );

  // Reference model: pixel n of a line reads address floor(n*step/128) mod 2^LB_AW.
  int m_pix_clks, m_strobes, m_step, m_hs, m_he, m_border;
  int m_addr, m_win, m_act1, m_act2, m_pal, m_rgb, m_bank, m_line_ok;

  task automatic model_reset();
    m_pix_clks = 0; m_strobes = 0; m_step = 128; m_hs = 0; m_he = AP; m_border = 0;
    m_addr = 0; m_win = 0; m_act1 = 0; m_act2 = 0; m_pal = 0; m_rgb = 0; m_bank = 0; m_line_ok = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    int idx;
    bit stb;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rgb  = m_act2 ? palfn(m_pal) : 0;
      m_pal  = (m_act1 != 0 && m_win != 0) ? lbfn(m_addr) : m_border;
      m_act2 = m_act1;
      m_act1 = (next_pixel && (m_line_ok != 0 || next_line)) ? 1 : 0;
      stb = 1'b0;
      if (next_line) begin
        m_pix_clks = next_pixel ? 1 : 0;
        m_strobes = 0; m_addr = 0; m_win = 0; m_line_ok = 1;
        m_hs = int'(hstart); m_he = int'(hstop); m_border = int'(border_color);
`ifdef COMPOSITE_FETCH_HSCALE_EN
        m_step = int'(hscale);
`else
        m_step = 128;
`endif
      end else if (next_pixel) begin
        stb = (m_line_ok != 0) && (m_pix_clks % 2 == 1);
        m_pix_clks++;
      end
      if (stb) begin
        idx    = (m_strobes < AP) ? m_strobes : AP;
        m_addr = int'((longint'(m_strobes) * m_step) % (longint'(1) << ACCW)) >> 7;
        m_win  = (idx >= m_hs && idx < m_he) ? 1 : 0;
        m_strobes++;
      end
      if (next_frame)     m_bank = 0;
      else if (next_line) m_bank = 1 - m_bank;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("lb_bank", int'(lb_bank), m_bank);
    chk("lb_rd_addr", int'(lb_rd_addr), m_addr);
    chk("pal_addr", int'(pal_addr), m_pal);
    chk("palette_rgb", int'(palette_rgb_data), m_rgb);
  endtask

  task automatic cyc(input bit nf, input bit nl, input bit np);
    next_frame = nf; next_line = nl; next_pixel = np;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic addr_seq(input int hs, input int exp[5]);
    hscale = 8'(hs); hstart = 10'd0; hstop = 10'd640;
    cyc(0, 1, 0);
    for (int j = 0; j < 5; j++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("seq_addr", int'(lb_rd_addr), exp[j]);
      if (j > 0) chk("seq_rgb_latency", int'(palette_rgb_data), palfn(lbfn(exp[j-1])));
    end
    repeat (4) cyc(0, 0, 0);
  endtask

  typedef struct {
    bit nf;
    bit nl;
    int exp_bank;
  } bank_vec_t;

  initial begin
    bank_vec_t bank_tbl[6];
    int exp_a[5];
    int exp_b[5];

    bank_tbl[0] = '{nf: 1'b0, nl: 1'b1, exp_bank: 1};
    bank_tbl[1] = '{nf: 1'b1, nl: 1'b1, exp_bank: 0};
    bank_tbl[2] = '{nf: 1'b0, nl: 1'b1, exp_bank: 1};
    bank_tbl[3] = '{nf: 1'b0, nl: 1'b1, exp_bank: 0};
    bank_tbl[4] = '{nf: 1'b0, nl: 1'b1, exp_bank: 1};
    bank_tbl[5] = '{nf: 1'b1, nl: 1'b0, exp_bank: 0};

    rst_n = 1'b0; next_frame = 1'b0; next_line = 1'b0; next_pixel = 1'b0;
    hscale = 8'd128; hstart = 10'd0; hstop = 10'd640; border_color = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_bank", int'(lb_bank), 0);
    chk("reset_addr", int'(lb_rd_addr), 0);
    chk("reset_pal", int'(pal_addr), 0);
    chk("reset_rgb", int'(palette_rgb_data), 0);
    rst_n = 1'b1;
    repeat (2) cyc(0, 0, 1);

    for (int i = 0; i < 6; i++) begin
      cyc(bank_tbl[i].nf, bank_tbl[i].nl, 1'b0);
      chk("bank_table", int'(lb_bank), bank_tbl[i].exp_bank);
    end

    exp_a = '{0, 1, 2, 3, 4};
    addr_seq(128, exp_a);
`ifdef COMPOSITE_FETCH_HSCALE_EN
    exp_a = '{0, 0, 1, 1, 2};
    exp_b = '{0, 1, 3, 5, 7};
`else
    exp_a = '{0, 1, 2, 3, 4};
    exp_b = '{0, 1, 2, 3, 4};
`endif
    addr_seq(64, exp_a);
    addr_seq(255, exp_b);

    // Window/border line with a mid-line config change that must not take effect.
    hscale = 8'd128; hstart = 10'd16; hstop = 10'd624; border_color = 8'h05;
    cyc(0, 1, 0);
    for (int c = 0; c < 1280; c++) begin
      if (c == 300) begin hstart = 10'd0; hstop = 10'd1; border_color = 8'hEE; end
      cyc(0, 0, 1);
    end
    repeat (4) cyc(0, 0, 0);

    // Randomised lines: gaps in next_pixel, coincident line/pixel, empty windows, saturation.
    for (int l = 0; l < 5; l++) begin
      hscale = 8'($urandom_range(1, 255));
      hstart = 10'($urandom_range(0, 700));
      hstop  = (l == 3) ? 10'd5 : 10'($urandom_range(0, 1023));
      if (l == 3) hstart = 10'd100;
      border_color = 8'($urandom);
      cyc((l == 2), 1, 1'($urandom));
      for (int c = 0; c < 1320; c++) begin
        if (c == 500) begin hscale = 8'($urandom); border_color = 8'($urandom); end
        cyc(0, 0, ($urandom_range(0, 15) != 0));
      end
      repeat (3) cyc(0, 0, 0);
    end

    // Reset asserted mid-line around pixel 300.
    hscale = 8'd128; hstart = 10'd0; hstop = 10'd640; border_color = 8'h33;
    cyc(0, 1, 0);
    for (int c = 0; c < 602; c++) cyc(0, 0, 1);
    chk("pre_reset_strobes", m_strobes, 301);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bank", int'(lb_bank), 0);
    chk("async_addr", int'(lb_rd_addr), 0);
    chk("async_pal", int'(pal_addr), 0);
    chk("async_rgb", int'(palette_rgb_data), 0);
    @(negedge clk);
    cyc(0, 0, 1);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(0, 0, 1);
      chk("post_reset_rgb", int'(palette_rgb_data), 0);
      chk("post_reset_addr", int'(lb_rd_addr), 0);
    end
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("restart_addr", int'(lb_rd_addr), 0);
    for (int c = 0; c < 6; c++) cyc(0, 0, 1);
    chk("restart_addr2", int'(lb_rd_addr), 3);
    chk("restart_rgb", int'(palette_rgb_data), palfn(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
